viterbi_channel: RTL and testbench

Synthesizable, deterministic channel-impairment stage between the convolutional encoder and the Viterbi decoder. It registers each 2-bit encoder symbol and XORs a pseudo-random error mask into it during a bounded injection window, with optional burst mode. It keeps symbol, errored-symbol and flipped-bit counters so benches and FPGA builds get a reproducible bit-error pattern without `$random`.

---
 rtl/viterbi_chan_pkg.sv | 23 ++
 rtl/chan_lfsr.sv | 29 ++
 rtl/viterbi_channel.sv | 168 ++++++++++++++++
 tb/tb_viterbi_channel.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_chan_pkg.sv
// Shared state type, LFSR polynomial and small bit helpers for the
// channel-impairment stage in front of the Viterbi decoder.
package viterbi_chan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    INJECT = 2'd1,
    BURST  = 2'd2,
    DONE   = 2'd3
  } chan_state_t;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  // Right-shifting Galois step; taps x^32+x^22+x^2+x+1.
  function automatic logic [31:0] lfsr_next(logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

  function automatic logic [1:0] popcount2(logic [1:0] m);
    return {1'b0, m[0]} + {1'b0, m[1]};
  endfunction

endpackage

// File: rtl/chan_lfsr.sv
// 32-bit Galois LFSR that steps once per asserted adv_i and restarts
// from SEED on reset so error patterns replay exactly.
module chan_lfsr
  import viterbi_chan_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE1_1234
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        adv_i,
  output logic [31:0] state_o
);

  logic [31:0] r_state;

  // State register: advance only when a symbol is presented.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= SEED;
    end else if (adv_i) begin
      r_state <= lfsr_next(r_state);
    end else begin
      r_state <= r_state;
    end
  end

  assign state_o = r_state;

endmodule

// File: rtl/viterbi_channel.sv
// Channel-impairment stage: registers each encoder symbol, XORs in an
// LFSR-driven error mask inside a bounded window, and counts errors.
module viterbi_channel
  import viterbi_chan_pkg::*;
#(
  parameter int          N         = 5,
  parameter int          WINDOW    = 256,
  parameter int          BURST_LEN = 4,
  parameter logic [31:0] SEED      = 32'hACE1_1234,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_i,
  input  logic             burst_en_i,
  input  logic             valid_i,
  input  logic [1:0]       d_in,
  output logic             valid_o,
  output logic [1:0]       d_out,
  output logic [1:0]       err_mask_o,
  output logic             burst_active_o,
  output logic             done_o,
  output logic [CNT_W-1:0] sym_ct_o,
  output logic [CNT_W-1:0] err_sym_ct_o,
  output logic [CNT_W-1:0] bad_bit_ct_o
);

  localparam int          BW       = $clog2(BURST_LEN + 1);
  localparam logic [31:0] LOW_MASK = (32'd1 << N) - 32'd1;

  function automatic logic [CNT_W-1:0] sat_add(logic [CNT_W-1:0] a, logic [1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  logic [31:0]      w_lfsr;
  logic             w_trig;
  logic [1:0]       w_cand_raw;
  logic [1:0]       w_cand;
  logic [1:0]       w_mask;
  logic             w_burst;
  logic             w_count;
  logic [CNT_W-1:0] w_sym_inc;
  chan_state_t      w_next_state;
  logic [BW-1:0]    w_next_bct;

  chan_state_t      r_state;
  logic [BW-1:0]    r_burst_ct;
  logic             r_valid;
  logic [1:0]       r_dout;
  logic [1:0]       r_mask;
  logic             r_burst;
  logic             r_done;
  logic [CNT_W-1:0] r_sym_ct;
  logic [CNT_W-1:0] r_err_ct;
  logic [CNT_W-1:0] r_bad_ct;

  chan_lfsr #(.SEED(SEED)) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .adv_i   (valid_i),
    .state_o (w_lfsr)
  );

  // Trigger and candidate come from the LFSR value before this symbol's step.
  assign w_trig     = (w_lfsr & LOW_MASK) < 32'd2;
  assign w_cand_raw = 2'(w_lfsr >> N);
  assign w_cand     = (w_cand_raw == 2'b00) ? 2'b11 : w_cand_raw;
  assign w_sym_inc  = sat_add(r_sym_ct, 2'd1);

  // Next-state, mask and window bookkeeping for the symbol on d_in.
  always_comb begin
    w_mask       = 2'b00;
    w_burst      = 1'b0;
    w_count      = 1'b0;
    w_next_state = r_state;
    w_next_bct   = r_burst_ct;
    case (r_state)
      IDLE, INJECT: begin
        if (enable_i) begin
          w_count      = 1'b1;
          w_next_state = INJECT;
          if (w_trig) begin
            w_mask = w_cand;
            if (burst_en_i && (BURST_LEN > 1)) begin
              w_burst      = 1'b1;
              w_next_state = BURST;
              w_next_bct   = BW'(1);
            end else begin
              w_burst = 1'b0;
            end
          end else begin
            w_mask = 2'b00;
          end
        end else begin
          w_count = 1'b0;
        end
      end
      BURST: begin
        if (enable_i) begin
          w_count = 1'b1;
          w_mask  = w_cand;
          w_burst = 1'b1;
          if (32'(r_burst_ct) + 32'd1 == 32'(BURST_LEN)) begin
            w_next_state = INJECT;
            w_next_bct   = '0;
          end else begin
            w_next_bct = r_burst_ct + BW'(1);
          end
        end else begin
          w_count = 1'b0;
        end
      end
      default: begin
        w_count = 1'b0;
      end
    endcase
    // The window-closing symbol is still injected; any burst is cut here.
    if (w_count && (32'(w_sym_inc) == 32'(WINDOW))) begin
      w_next_state = DONE;
      w_next_bct   = '0;
    end else begin
      w_next_state = w_next_state;
    end
  end

  // Output registers, FSM state and saturating counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_burst_ct <= '0;
      r_valid    <= 1'b0;
      r_dout     <= 2'b00;
      r_mask     <= 2'b00;
      r_burst    <= 1'b0;
      r_done     <= 1'b0;
      r_sym_ct   <= '0;
      r_err_ct   <= '0;
      r_bad_ct   <= '0;
    end else begin
      r_valid <= valid_i;
      if (valid_i) begin
        r_state    <= w_next_state;
        r_burst_ct <= w_next_bct;
        r_dout     <= d_in ^ w_mask;
        r_mask     <= w_mask;
        r_burst    <= w_burst;
        r_done     <= (w_next_state == DONE);
        if (w_count) r_sym_ct <= w_sym_inc;
        if (w_mask != 2'b00) begin
          r_err_ct <= sat_add(r_err_ct, 2'd1);
          r_bad_ct <= sat_add(r_bad_ct, popcount2(w_mask));
        end
      end
    end
  end

  assign valid_o        = r_valid;
  assign d_out          = r_dout;
  assign err_mask_o     = r_mask;
  assign burst_active_o = r_burst;
  assign done_o         = r_done;
  assign sym_ct_o       = r_sym_ct;
  assign err_sym_ct_o   = r_err_ct;
  assign bad_bit_ct_o   = r_bad_ct;

endmodule

// File: tb/tb_viterbi_channel.sv
// Scoreboard bench for viterbi_channel: random symbols are fed to a
// behavioural channel model whose expectations are checked by a monitor.
module tb_viterbi_channel;

  localparam int          N         = 2;
  localparam int          WINDOW    = 40;
  localparam int          BURST_LEN = 3;
  localparam logic [31:0] SEED      = 32'hACE1_1234;
  localparam int          CNT_W     = 16;
  localparam int          L         = 120;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             enable_i = 1'b0;
  logic             burst_en_i = 1'b0;
  logic             valid_i = 1'b0;
  logic [1:0]       d_in = 2'b00;
  logic             valid_o;
  logic [1:0]       d_out;
  logic [1:0]       err_mask_o;
  logic             burst_active_o;
  logic             done_o;
  logic [CNT_W-1:0] sym_ct_o;
  logic [CNT_W-1:0] err_sym_ct_o;
  logic [CNT_W-1:0] bad_bit_ct_o;

  viterbi_channel #(
    .N(N), .WINDOW(WINDOW), .BURST_LEN(BURST_LEN), .SEED(SEED), .CNT_W(CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable_i       (enable_i),
    .burst_en_i     (burst_en_i),
    .valid_i        (valid_i),
    .d_in           (d_in),
    .valid_o        (valid_o),
    .d_out          (d_out),
    .err_mask_o     (err_mask_o),
    .burst_active_o (burst_active_o),
    .done_o         (done_o),
    .sym_ct_o       (sym_ct_o),
    .err_sym_ct_o   (err_sym_ct_o),
    .bad_bit_ct_o   (bad_bit_ct_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] dout;
    logic [1:0] mask;
    logic       ba;
    logic       done;
    int         sym;
    int         err;
    int         bad;
  } exp_t;

  exp_t        q[$];
  logic [1:0]  got_masks[$];
  logic [1:0]  run1_masks[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  // Reference model: window position, remaining burst symbols, running totals.
  logic [31:0] m_lfsr;
  int          m_count, m_err, m_bad, m_left;
  bit          m_done;
  logic [1:0]  last_dout;

  logic        st_v[L];
  logic        st_e[L];
  logic        st_b[L];
  logic [1:0]  st_d[L];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_lfsr = SEED; m_count = 0; m_err = 0; m_bad = 0; m_left = 0; m_done = 0;
    last_dout = 2'b00;
    q.delete();
  endtask

  task automatic model_step(input logic en, input logic ben, input logic [1:0] d);
    exp_t       e;
    int         low, cand;
    logic [1:0] mk;
    bit         ba;
    mk   = 2'b00;
    ba   = 0;
    low  = int'(m_lfsr % (32'd1 << N));
    cand = int'((m_lfsr >> N) % 32'd4);
    if (cand == 0) cand = 3;
    if (!m_done && en) begin
      m_count++;
      if (m_left > 0) begin
        mk = 2'(cand); ba = 1; m_left--;
      end else if (low < 2) begin
        mk = 2'(cand);
        if (ben && BURST_LEN > 1) begin ba = 1; m_left = BURST_LEN - 1; end
      end
      if (m_count == WINDOW) begin m_done = 1; m_left = 0; end
    end
    if (mk != 2'b00) m_err++;
    m_bad += int'(mk[0]) + int'(mk[1]);
    e = '{dout: d ^ mk, mask: mk, ba: ba, done: m_done, sym: m_count, err: m_err, bad: m_bad};
    q.push_back(e);
    m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 32'h8020_0003) : (m_lfsr >> 1);
  endtask

  task automatic send(input logic v, input logic en, input logic ben, input logic [1:0] d);
    @(posedge clk);
    #1;
    valid_i = v; enable_i = en; burst_en_i = ben; d_in = d;
    if (v) model_step(en, ben, d);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, valid_o, 0);
    check({tag, "_dout"}, d_out, 0);
    check({tag, "_mask"}, err_mask_o, 0);
    check({tag, "_burst"}, burst_active_o, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_sym"}, sym_ct_o, 0);
    check({tag, "_err"}, err_sym_ct_o, 0);
    check({tag, "_bad"}, bad_bit_ct_o, 0);
  endtask

  task automatic run_stim(input int upto);
    for (int i = 0; i < upto; i++) send(st_v[i], st_e[i], st_b[i], st_d[i]);
    for (int i = 0; i < 3; i++) send(1'b0, 1'b0, 1'b0, 2'b00);
    check("queue_drained", q.size(), 0);
  endtask

  exp_t mon_e;
  // Monitor: pop an expectation for each presented symbol, check holds otherwise.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (valid_o) begin
        if (q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_valid: got valid_o=1 expected no output at %0t", $time);
        end else begin
          mon_e = q.pop_front();
          check("d_out", d_out, mon_e.dout);
          check("err_mask", err_mask_o, mon_e.mask);
          check("burst_active", burst_active_o, mon_e.ba);
          check("done", done_o, mon_e.done);
          check("sym_ct", sym_ct_o, mon_e.sym);
          check("err_sym_ct", err_sym_ct_o, mon_e.err);
          check("bad_bit_ct", bad_bit_ct_o, mon_e.bad);
          last_dout = mon_e.dout;
          got_masks.push_back(err_mask_o);
        end
      end else begin
        check("d_out_hold", d_out, last_dout);
      end
    end
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    for (int i = 0; i < L; i++) begin
      st_v[i] = ($urandom_range(3, 0) != 0);
      st_e[i] = ($urandom_range(6, 0) != 0);
      st_b[i] = $urandom_range(1, 0) != 0;
      st_d[i] = 2'($urandom_range(3, 0));
    end
    model_reset();
    #2 rst = 1'b0;
    #1 check_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // Clean pass-through before injection is ever enabled.
    send(1'b1, 1'b0, 1'b0, 2'b10);
    send(1'b0, 1'b0, 1'b0, 2'b00);
    send(1'b0, 1'b0, 1'b0, 2'b00);

    // Run 1 from a fresh reset, recording the applied masks.
    @(negedge clk); rst = 1'b0; model_reset();
    @(negedge clk); rst = 1'b1;
    got_masks.delete();
    run_stim(L);
    run1_masks = got_masks;

    // Run 2: replay until a burst is in flight, then reset asynchronously.
    @(negedge clk); rst = 1'b0; model_reset();
    @(negedge clk); rst = 1'b1;
    found = 0;
    for (int i = 0; i < L && !found; i++) begin
      send(st_v[i], st_e[i], st_b[i], st_d[i]);
      if (i >= 10 && st_v[i] && m_left > 0) found = 1;
    end
    @(posedge clk);
    #2;
    if (found) check("burst_before_reset", burst_active_o, 1);
    rst = 1'b0; valid_i = 1'b0;
    #1 check_zero("midburst_reset");
    model_reset();
    @(negedge clk);
    @(negedge clk); rst = 1'b1;

    // Run 3: identical stimulus must reproduce run 1 bit for bit.
    got_masks.delete();
    run_stim(L);
    check("rerun_len", got_masks.size(), run1_masks.size());
    for (int i = 0; i < got_masks.size() && i < run1_masks.size(); i++)
      check("rerun_mask", got_masks[i], run1_masks[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
